led_chase_game: RTL and testbench
=================================

# led_chase_game

Parametrised LED chase/reaction game core for the board top level. One runner LED moves between two fixed wall LEDs, speeding up on every step. The player reverses it with a button and loses a life when it reaches a wall-adjacent position. Adds configurable field width, speed profile, multiple lives, pause-on-hit and a saturating stopwatch; 7-segment decoding stays in the top level (bin2dec/dec_7seg).

## Interface
- N_LEDS, 18: total LEDs including both walls; legal range 6..32.
- TICK_10MS, 500000: CLK cycles per 10 ms stopwatch tick.
- START_PERIOD, 5000000: CLK cycles per runner step at game start.
- PERIOD_STEP, 15000: period decrement applied after every step.
- MIN_PERIOD, 500000: period floor; must be ≥ 2 and ≤ START_PERIOD.
- LIVES, 3: lives per game; range 1..15.
- CLK  in  1  system clock; all logic on posedge.
- RESET  in  1  asynchronous, active-low reset.
- ENTER  in  1  one-cycle active-low strobe from puls_gen: start/resume.
- STOP  in  1  one-cycle active-low strobe from puls_gen: pause/resume.
- CHANGE  in  1  one-cycle active-low strobe from puls_gen: reverse direction.
- LED  out  N_LEDS  led[0] and led[N_LEDS-1] are walls; exactly one interior bit is the runner.
- STATE  out  2  0 IDLE, 1 RUN, 2 PAUSE, 3 OVER.
- LIVES_LEFT  out  4  remaining lives.
- SEC  out  7  stopwatch seconds, 0..99.
- CSEC  out  7  stopwatch hundredths, 0..99.

## Operation
- Internal: pos (runner index), dir (0 = toward index 0, 1 = toward N_LEDS-1), period (32 bit), step counter, tick counter.
- CENTER = N_LEDS/2 (integer). LED = walls | (1 << pos) in every state.
- IDLE: pos=CENTER, dir=0, period=START_PERIOD, counters 0, stopwatch 0, LIVES_LEFT=LIVES. ENTER → RUN.
- RUN: step counter increments; when counter ≥ period-1 it clears, pos moves one toward dir, period ← max(period-PERIOD_STEP, MIN_PERIOD) (no underflow). Stopwatch runs. CHANGE toggles dir. STOP → PAUSE. ENTER ignored.
- Hit: a step landing on pos 1 or pos N_LEDS-2. LIVES_LEFT decrements. If the result is 0 → OVER; otherwise → PAUSE with pos=CENTER, dir=0 and step counter 0; period is retained.
- PAUSE: everything frozen. ENTER or STOP → RUN. CHANGE ignored.
- OVER: frozen; runner held on the hit position; stopwatch held. Only RESET leaves OVER (→ IDLE).
- Stopwatch: tick counter reaches TICK_10MS-1 → clears, CSEC+1. CSEC 99 wraps to 0 with SEC+1. At SEC=99, CSEC=99 both saturate.

## Timing
- Reset (asynchronous, immediate): STATE=0, LED=walls+CENTER, LIVES_LEFT=LIVES, SEC=0, CSEC=0, period=START_PERIOD, all counters 0, dir=0.
- All outputs registered. A strobe sampled at edge k changes STATE/dir at edge k (visible after k).
- IDLE→RUN: first step occurs START_PERIOD cycles after the ENTER edge; first CSEC increment after TICK_10MS cycles.
- Step n uses period_n = max(START_PERIOD - (n-1)·PERIOD_STEP, MIN_PERIOD).
- Simultaneous events in RUN, same cycle:
  - step + CHANGE: step uses old dir; new dir applies from the next step.
  - hit + STOP: hit handling wins; STOP is dropped.
  - hit + CHANGE: dir forced to 0.
- Counters freeze in PAUSE and resume without reset, except the step counter, which clears on a hit.
- A strobe held low more than one cycle is a protocol violation; the block acts on every low cycle.

## Test plan
- Reset/idle: N_LEDS=8, RESET low then high → LED=8'b1001_0001, STATE=0, LIVES_LEFT=LIVES; 100 idle cycles with no strobes → unchanged.
- Speed-up and floor: START_PERIOD=10, PERIOD_STEP=3, MIN_PERIOD=4, N_LEDS=32, ENTER → steps at cycle offsets 10, 17, 21, 25, 29 after ENTER (floor at 4, no wrap).
- Hit and lives: N_LEDS=8, LIVES=2, START_PERIOD=4, PERIOD_STEP=0, no CHANGE → after 3 steps pos=1: LIVES_LEFT=1, STATE=2, pos=4. ENTER, 3 more steps → STATE=3, LIVES_LEFT=0, LED bit1 set. ENTER/STOP in OVER ignored.
- Direction change: CHANGE pulsed in the same cycle as step 1 → step 1 goes to pos 3; step 2 goes to pos 4 (N_LEDS=8).
- Stopwatch: TICK_10MS=2 in RUN for 20000 cycles → SEC=99, CSEC=99, held after a further 1000 cycles. STOP mid-run freezes SEC/CSEC until the next STOP.
- Async reset mid-RUN: drop RESET between clock edges → all outputs at reset values before the next edge. STATE=0 after release.

Source files
------------

// File: rtl/led_chase_game.sv
// ---------------------------------------------------------------------------
// led_chase_game
//
// Reaction-game core: a single runner LED moves between two fixed wall LEDs,
// taking one step every `period` clock cycles. The period shrinks after every
// step down to a floor. The player reverses the runner with CHANGE. A step
// that lands next to a wall costs a life. The game pauses after the hit, or
// ends when no lives remain. A 10 ms stopwatch runs while the game is in RUN
// and saturates at 99.99 s.
//
// Parameters
//   N_LEDS       total LEDs including both walls (6..32)
//   TICK_10MS    clock cycles per stopwatch hundredth
//   START_PERIOD clock cycles per runner step at game start
//   PERIOD_STEP  period decrement applied after each step
//   MIN_PERIOD   period floor (2 .. START_PERIOD)
//   LIVES        lives per game (1..15)
//
// Ports
//   CLK         system clock, all logic on posedge
//   RESET       asynchronous active-low reset
//   ENTER       active-low one-cycle strobe: start / resume
//   STOP        active-low one-cycle strobe: pause / resume
//   CHANGE      active-low one-cycle strobe: reverse direction
//   LED         wall LEDs (bit 0 and bit N_LEDS-1) plus the runner bit
//   STATE       0 IDLE, 1 RUN, 2 PAUSE, 3 OVER
//   LIVES_LEFT  remaining lives
//   SEC         stopwatch seconds 0..99
//   CSEC        stopwatch hundredths 0..99
// ---------------------------------------------------------------------------
module led_chase_game #(
  parameter int N_LEDS       = 18,
  parameter int TICK_10MS    = 500000,
  parameter int START_PERIOD = 5000000,
  parameter int PERIOD_STEP  = 15000,
  parameter int MIN_PERIOD   = 500000,
  parameter int LIVES        = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ENTER,
  input  logic              STOP,
  input  logic              CHANGE,
  output logic [N_LEDS-1:0] LED,
  output logic [1:0]        STATE,
  output logic [3:0]        LIVES_LEFT,
  output logic [6:0]        SEC,
  output logic [6:0]        CSEC
);

  localparam int POS_W = $clog2(N_LEDS);

  localparam logic [POS_W-1:0]  CENTER_POS = POS_W'(N_LEDS / 2);
  localparam logic [POS_W-1:0]  HIT_LO     = POS_W'(1);
  localparam logic [POS_W-1:0]  HIT_HI     = POS_W'(N_LEDS - 2);
  localparam logic [POS_W-1:0]  POS_ONE    = POS_W'(1);

  localparam logic [31:0]       START_P    = 32'(START_PERIOD);
  localparam logic [31:0]       STEP_P     = 32'(PERIOD_STEP);
  localparam logic [31:0]       MIN_P      = 32'(MIN_PERIOD);
  localparam logic [31:0]       TICK_P     = 32'(TICK_10MS);
  localparam logic [3:0]        LIVES_INIT = 4'(LIVES);

  localparam logic [N_LEDS-1:0] LED_ONE    = N_LEDS'(1);
  localparam logic [N_LEDS-1:0] WALLS      = LED_ONE | (LED_ONE << (N_LEDS - 1));

  localparam logic [6:0]        CNT_MAX    = 7'd99;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t              state;
  logic [POS_W-1:0]    pos;
  logic                dir;
  logic [31:0]         period;
  logic [31:0]         step_cnt;
  logic [31:0]         tick_cnt;
  logic [3:0]          lives;
  logic [6:0]          sec;
  logic [6:0]          csec;
  logic [N_LEDS-1:0]   led;

  // Strobes arrive active-low; work with active-high requests internally.
  logic enter_req;
  logic stop_req;
  logic change_req;

  assign enter_req  = ~ENTER;
  assign stop_req   = ~STOP;
  assign change_req = ~CHANGE;

  function automatic logic [N_LEDS-1:0] led_of(input logic [POS_W-1:0] p);
    led_of = WALLS | (LED_ONE << p);
  endfunction

  // Step event, where the runner lands, and the decayed period.
  logic             step_due;
  logic [POS_W-1:0] pos_step;
  logic             hit;
  logic [31:0]      period_next;

  always_comb begin
    step_due    = 1'b0;
    pos_step    = pos;
    hit         = 1'b0;
    period_next = period;

    step_due = (state == RUN) && (step_cnt >= (period - 32'd1));
    pos_step = dir ? (pos + POS_ONE) : (pos - POS_ONE);
    hit      = step_due && ((pos_step == HIT_LO) || (pos_step == HIT_HI));

    // Compare the headroom above the floor so the subtraction never wraps.
    if ((period - MIN_P) >= STEP_P) begin
      period_next = period - STEP_P;
    end else begin
      period_next = MIN_P;
    end
  end

  // Game FSM: runner position, direction, speed and lives.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      pos      <= CENTER_POS;
      dir      <= 1'b0;
      period   <= START_P;
      step_cnt <= 32'd0;
      lives    <= LIVES_INIT;
      led      <= led_of(CENTER_POS);
    end else begin
      case (state)
        IDLE: begin
          pos      <= CENTER_POS;
          dir      <= 1'b0;
          period   <= START_P;
          step_cnt <= 32'd0;
          lives    <= LIVES_INIT;
          led      <= led_of(CENTER_POS);
          if (enter_req) begin
            state <= RUN;
          end
        end

        RUN: begin
          if (step_due) begin
            step_cnt <= 32'd0;
            period   <= period_next;
            if (hit) begin
              // A hit overrides STOP and CHANGE: the runner always
              // restarts toward index 0.
              lives <= lives - 4'd1;
              dir   <= 1'b0;
              if (lives == 4'd1) begin
                state <= OVER;
                pos   <= pos_step;
                led   <= led_of(pos_step);
              end else begin
                state <= PAUSE;
                pos   <= CENTER_POS;
                led   <= led_of(CENTER_POS);
              end
            end else begin
              // This step already used the old direction; a CHANGE in the
              // same cycle takes effect from the next step.
              pos <= pos_step;
              led <= led_of(pos_step);
              if (change_req) begin
                dir <= ~dir;
              end
              if (stop_req) begin
                state <= PAUSE;
              end
            end
          end else begin
            step_cnt <= step_cnt + 32'd1;
            if (change_req) begin
              dir <= ~dir;
            end
            if (stop_req) begin
              state <= PAUSE;
            end
          end
        end

        PAUSE: begin
          if (enter_req || stop_req) begin
            state <= RUN;
          end
        end

        OVER: begin
          // Terminal until RESET; runner stays on the hit position.
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Stopwatch: advances only in RUN, saturates at 99.99.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      tick_cnt <= 32'd0;
      sec      <= 7'd0;
      csec     <= 7'd0;
    end else if (state == RUN) begin
      if (tick_cnt >= (TICK_P - 32'd1)) begin
        tick_cnt <= 32'd0;
        if (csec == CNT_MAX) begin
          if (sec != CNT_MAX) begin
            csec <= 7'd0;
            sec  <= sec + 7'd1;
          end
        end else begin
          csec <= csec + 7'd1;
        end
      end else begin
        tick_cnt <= tick_cnt + 32'd1;
      end
    end
  end

  assign LED        = led;
  assign STATE      = state;
  assign LIVES_LEFT = lives;
  assign SEC        = sec;
  assign CSEC       = csec;

endmodule

// File: tb/tb_led_chase_game.sv
// ---------------------------------------------------------------------------
// tb_led_chase_game
//
// Three game instances with different parameter sets share one clock:
//   A: 8 LEDs, 2 lives, fixed period 4      (reset, hits, lives, direction)
//   B: 32 LEDs, 10 ms tick = 2 cycles       (stopwatch, pause, async reset)
//   C: 32 LEDs, period 10 -3/step, floor 4  (speed-up profile)
// Step times of C are predicted at ENTER and queued; a negedge monitor pops
// and compares them as the runner moves.
// ---------------------------------------------------------------------------
module tb_led_chase_game;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A
  logic        rst_a, enter_a, stop_a, change_a;
  logic [7:0]  led_a;
  logic [1:0]  state_a;
  logic [3:0]  lives_a;
  logic [6:0]  sec_a, csec_a;

  // Instance B
  logic        rst_b, enter_b, stop_b, change_b;
  logic [31:0] led_b;
  logic [1:0]  state_b;
  logic [3:0]  lives_b;
  logic [6:0]  sec_b, csec_b;

  // Instance C
  logic        rst_c, enter_c, stop_c, change_c;
  logic [31:0] led_c;
  logic [1:0]  state_c;
  logic [3:0]  lives_c;
  logic [6:0]  sec_c, csec_c;

  led_chase_game #(
    .N_LEDS(8), .TICK_10MS(1000), .START_PERIOD(4),
    .PERIOD_STEP(0), .MIN_PERIOD(2), .LIVES(2)
  ) dut_a (
    .CLK(clk), .RESET(rst_a), .ENTER(enter_a), .STOP(stop_a), .CHANGE(change_a),
    .LED(led_a), .STATE(state_a), .LIVES_LEFT(lives_a), .SEC(sec_a), .CSEC(csec_a)
  );

  led_chase_game #(
    .N_LEDS(32), .TICK_10MS(2), .START_PERIOD(1000000),
    .PERIOD_STEP(0), .MIN_PERIOD(2), .LIVES(3)
  ) dut_b (
    .CLK(clk), .RESET(rst_b), .ENTER(enter_b), .STOP(stop_b), .CHANGE(change_b),
    .LED(led_b), .STATE(state_b), .LIVES_LEFT(lives_b), .SEC(sec_b), .CSEC(csec_b)
  );

  led_chase_game #(
    .N_LEDS(32), .TICK_10MS(1000), .START_PERIOD(10),
    .PERIOD_STEP(3), .MIN_PERIOD(4), .LIVES(3)
  ) dut_c (
    .CLK(clk), .RESET(rst_c), .ENTER(enter_c), .STOP(stop_c), .CHANGE(change_c),
    .LED(led_c), .STATE(state_c), .LIVES_LEFT(lives_c), .SEC(sec_c), .CSEC(csec_c)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          cyc;
    logic [31:0] led;
  } step_t;

  step_t exp_q[$];
  logic  mon_c = 1'b0;
  logic [31:0] prev_c;

  localparam logic [31:0] WALLS32 = 32'h8000_0001;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // 0 A.ENTER, 1 A.STOP, 2 A.CHANGE, 3 B.ENTER, 4 B.STOP, 5 C.ENTER
  task automatic drive(input int sig, input logic v);
    case (sig)
      0: enter_a  = v;
      1: stop_a   = v;
      2: change_a = v;
      3: enter_b  = v;
      4: stop_b   = v;
      5: enter_c  = v;
      default: ;
    endcase
  endtask

  // One-cycle low pulse; returns the number of the edge that sampled it.
  task automatic pulse(input int sig, output int edge_n);
    @(posedge clk);
    #1;
    drive(sig, 1'b0);
    @(posedge clk);
    #1;
    edge_n = cyc;
    drive(sig, 1'b1);
  endtask

  // Scoreboard monitor for instance C runner steps.
  initial begin
    step_t item;
    prev_c = '0;
    forever begin
      @(negedge clk);
      if (mon_c && (led_c !== prev_c)) begin
        if (exp_q.size() == 0) begin
          check("c_unexpected_step", 64'(cyc), 64'(0));
        end else begin
          item = exp_q.pop_front();
          check("c_step_cycle", 64'(cyc), 64'(item.cyc));
          check("c_step_led", 64'(led_c), 64'(item.led));
        end
      end
      prev_c = led_c;
    end
  end

  initial begin
    int e;
    int offs [5];
    step_t it;

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    enter_a = 1'b1; stop_a = 1'b1; change_a = 1'b1;
    enter_b = 1'b1; stop_b = 1'b1; change_b = 1'b1;
    enter_c = 1'b1; stop_c = 1'b1; change_c = 1'b1;

    // Reset and idle
    tick(3);
    check("rst_led",   64'(led_a),   64'(8'b1001_0001));
    check("rst_state", 64'(state_a), 64'(0));
    check("rst_lives", 64'(lives_a), 64'(2));
    check("rst_sec",   64'(sec_a),   64'(0));
    check("rst_csec",  64'(csec_a),  64'(0));
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    tick(100);
    check("idle_led",   64'(led_a),   64'(8'b1001_0001));
    check("idle_state", 64'(state_a), 64'(0));
    check("idle_lives", 64'(lives_a), 64'(2));
    check("idle_csec",  64'(csec_a),  64'(0));

    // Speed-up and floor on C: steps at +10, +17, +21, +25, +29
    offs[0] = 10; offs[1] = 17; offs[2] = 21; offs[3] = 25; offs[4] = 29;
    mon_c = 1'b1;
    pulse(5, e);
    for (int i = 0; i < 5; i++) begin
      it.cyc = e + offs[i];
      it.led = WALLS32 | (32'd1 << (15 - i));
      exp_q.push_back(it);
    end
    tick(30);
    mon_c = 1'b0;
    check("c_steps_all_seen", 64'(exp_q.size()), 64'(0));
    check("c_state_run", 64'(state_c), 64'(1));

    // Hit and lives on A: period 4, runner 4 -> 3 -> 2 -> 1 (hit)
    pulse(0, e);
    tick(11);
    check("a_pos2_led",   64'(led_a),   64'(8'b1000_0101));
    check("a_pos2_state", 64'(state_a), 64'(1));
    tick(1);
    check("a_hit1_state", 64'(state_a), 64'(2));
    check("a_hit1_lives", 64'(lives_a), 64'(1));
    check("a_hit1_led",   64'(led_a),   64'(8'b1001_0001));
    pulse(0, e);
    tick(12);
    check("a_over_state", 64'(state_a), 64'(3));
    check("a_over_lives", 64'(lives_a), 64'(0));
    check("a_over_led",   64'(led_a),   64'(8'b1000_0011));
    pulse(0, e);
    pulse(1, e);
    tick(5);
    check("a_over_hold_state", 64'(state_a), 64'(3));
    check("a_over_hold_led",   64'(led_a),   64'(8'b1000_0011));
    check("a_over_hold_lives", 64'(lives_a), 64'(0));

    // Direction change coinciding with step 1 on A
    rst_a = 1'b0;
    tick(2);
    check("a_rst2_state", 64'(state_a), 64'(0));
    check("a_rst2_lives", 64'(lives_a), 64'(2));
    rst_a = 1'b1;
    tick(1);
    pulse(0, e);
    tick(3);
    drive(2, 1'b0);
    tick(1);
    drive(2, 1'b1);
    check("dir_step1_led", 64'(led_a), 64'(8'b1000_1001));
    tick(3);
    check("dir_hold_led",  64'(led_a), 64'(8'b1000_1001));
    tick(1);
    check("dir_step2_led", 64'(led_a), 64'(8'b1001_0001));
    tick(4);
    check("dir_step3_led", 64'(led_a), 64'(8'b1010_0001));
    tick(4);
    check("dir_hit_state", 64'(state_a), 64'(2));
    check("dir_hit_lives", 64'(lives_a), 64'(1));
    check("dir_hit_led",   64'(led_a),   64'(8'b1001_0001));

    // Stopwatch on B: one hundredth every 2 cycles
    pulse(3, e);
    tick(10);
    check("sw_csec5", 64'(csec_b), 64'(5));
    check("sw_sec0",  64'(sec_b),  64'(0));
    pulse(4, e);
    tick(50);
    check("sw_pause_state", 64'(state_b), 64'(2));
    check("sw_pause_csec",  64'(csec_b),  64'(6));
    pulse(4, e);
    tick(2);
    check("sw_resume_state", 64'(state_b), 64'(1));
    check("sw_resume_csec",  64'(csec_b),  64'(7));
    tick(20000);
    check("sw_sat_sec",  64'(sec_b),  64'(99));
    check("sw_sat_csec", 64'(csec_b), 64'(99));
    tick(1000);
    check("sw_hold_sec",   64'(sec_b),   64'(99));
    check("sw_hold_csec",  64'(csec_b),  64'(99));
    check("sw_hold_state", 64'(state_b), 64'(1));
    check("sw_hold_led",   64'(led_b),   64'(WALLS32 | (32'd1 << 16)));

    // Asynchronous reset between edges on B
    #3;
    rst_b = 1'b0;
    #1;
    check("ar_state", 64'(state_b), 64'(0));
    check("ar_led",   64'(led_b),   64'(WALLS32 | (32'd1 << 16)));
    check("ar_sec",   64'(sec_b),   64'(0));
    check("ar_csec",  64'(csec_b),  64'(0));
    check("ar_lives", 64'(lives_b), 64'(3));
    tick(2);
    rst_b = 1'b1;
    tick(2);
    check("ar_release_state", 64'(state_b), 64'(0));
    check("ar_release_csec",  64'(csec_b),  64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
